invader_formation: RTL and testbench
====================================

// Module: invader_formation
// PURPOSE
//  Alien-formation engine, directly downstream of the VGA timing generator. Consumes xCount/yCount/displayArea.
//  Holds formation position, march direction and per-alien alive mask; steps the formation once every
//  FRAMES_PER_STEP frames, during vertical blank only, so there is no tearing.
//  Emits a per-pixel "alien here" flag plus the alien's column/row index for colour mux and bullet-collision logic.
// PARAMETERS
//  COLS            8    aliens per row
//  ROWS            4    alien rows
//  PITCH           32   cell pitch in px, x and y; power of 2; sprite 16x16 in top-left of cell, rest is gap
//  START_X         64   reset formation left edge (px)
//  START_Y         48   reset formation top edge (px)
//  STEP_PX         4    horizontal step per march tick
//  DROP_PX         16   vertical drop at an edge
//  FRAMES_PER_STEP 30   frames between march ticks (>=1)
//  X_MAX           640  right screen bound (exclusive)
//  LAND_Y          400  formation bottom >= LAND_Y -> landed
// PORTS
//  VGA_clk      in   1        pixel clock (25 MHz)
//  resetn       in   1        synchronous reset, active-low
//  xCount       in   10       horizontal pixel counter from timing gen
//  yCount       in   10       vertical line counter from timing gen
//  displayArea  in   1        active-video flag (timing gen: registered, 1 cycle behind counters)
//  kill_valid   in   1        1-cycle pulse: destroy alien (kill_col, kill_row)
//  kill_col     in   3        column of alien to destroy
//  kill_row     in   2        row of alien to destroy
//  alien_pixel  out  1        current pixel is a lit pixel of a live alien
//  pixel_col    out  3        column of that alien (valid when alien_pixel=1, else 0)
//  pixel_row    out  2        row of that alien (valid when alien_pixel=1, else 0)
//  form_x       out  10       formation left edge
//  form_y       out  10       formation top edge
//  alive        out  COLS*ROWS  alive mask, bit = row*COLS+col
//  landed       out  1        formation reached LAND_Y (sticky until reset)
//  all_dead     out  1        alive == 0 (combinational from mask)
// BEHAVIOUR
//  Synchronous reset, active-low; everything updates on posedge VGA_clk.
//   form_x=START_X; form_y=START_Y; dir=RIGHT; alive=all 1s; frame_cnt=0; anim=0; state=MARCH;
//   alien_pixel/pixel_col/pixel_row/landed=0.
//  Reset asserted mid-frame or mid-step restores all of the above on the next edge; no partial step survives.
//  frame_tick: 1-cycle pulse when xCount==0 && yCount==480 (start of vblank); exactly one per frame.
//  FW = COLS*PITCH-(PITCH-16) = 240; FH = ROWS*PITCH-(PITCH-16) = 112 (defaults).
//  FSM MARCH:
//   on frame_tick: if frame_cnt==FRAMES_PER_STEP-1 then frame_cnt<=0 and do step, else frame_cnt++.
//  Step when dir=RIGHT:
//   form_x+STEP_PX+FW > X_MAX -> form_y += DROP_PX, dir <= LEFT, form_x unchanged;
//   otherwise form_x += STEP_PX.
//  Step when dir=LEFT:
//   form_x < STEP_PX -> form_y += DROP_PX, dir <= RIGHT;
//   otherwise form_x -= STEP_PX.
//  Every step, including a drop, toggles anim.
//  Edge test uses the full formation width, not just the live columns.
//  After any step, if form_y(new)+FH >= LAND_Y: landed<=1, state -> HALT.
//  all_dead=1 in MARCH -> state -> HALT.
//  HALT: position, dir, anim and frame_cnt frozen. Rendering continues. Exit by reset only.
//  Kill: kill_valid clears alive[kill_row*COLS+kill_col] next edge, in any state.
//   Already-dead target -> no effect. Out-of-range row/col -> ignored.
//   Kill in the same cycle as a step: both apply.
//  Render pipeline, 2 cycles, counters -> alien_pixel:
//   S1 registers rx=xCount-form_x, ry=yCount-form_y (11-bit signed);
//    inside = rx,ry >= 0 && rx < COLS*PITCH && ry < ROWS*PITCH;
//    col = rx/PITCH, row = ry/PITCH, sx = rx%PITCH, sy = ry%PITCH.
//   S2 alien_pixel = inside && sx<16 && sy<16 && alive[row*COLS+col] && bitmap[anim][sy>>1][sx>>1]
//    && displayArea (displayArea is then aligned with S1).
//  Bitmap: 2 frames of 8x8 constant table. Rows 3 and 4 are all 1s in both frames; row 0 cols 0 and 7 are 0.
//  form_x/form_y change only at frame_tick (vblank), so the visible frame is always consistent.
// TESTING (bench drives xCount/yCount/displayArea directly; FRAMES_PER_STEP=1 unless stated)
//  1 Reset: resetn=0 one edge -> form_x=64, form_y=48, alive=32'hFFFFFFFF, landed=0, alien_pixel=0.
//  2 March: 3 frame_ticks -> form_x=76, form_y=48; FRAMES_PER_STEP=30: 29 ticks -> form_x=64, 30th -> 68.
//  3 Edge: tick until form_x=400 (84 ticks); next tick -> form_x=400, form_y=64, dir LEFT; next tick -> form_x=396.
//  4 Render: counters (64,54), displayArea=1 -> alien_pixel=1 two cycles later, col=0, row=0;
//    (84,54) -> 0 (gap); (64,48) -> 0 (bitmap row 0 col 0).
//  5 Kill: kill_valid with col=0, row=0 -> alive[0]=0; (64,54) now gives alien_pixel=0;
//    repeat kill -> mask unchanged; kill coinciding with a tick -> both applied.
//  6 Land/all_dead: march until form_y+112 >= 400 -> landed=1, further ticks leave form_x/y frozen;
//    separately kill all 32 -> all_dead=1, HALT; resetn=0 -> full reset values restored.

Source files
------------

// File: rtl/invader_formation.sv
// rtl/invader_formation.sv - alien formation march, kill mask and per-pixel render
//
// Purpose: holds the formation position, march direction and alive mask. The
// formation steps once every FRAMES_PER_STEP frames at the start of vertical
// blank, so a visible frame never shows a half-moved formation. A two-stage
// pipeline turns the timing-generator counters into an "alien here" flag plus
// the alien's column and row.
//
// Ports:
//   VGA_clk      pixel clock
//   resetn       synchronous reset, active-low
//   xCount       horizontal pixel counter
//   yCount       vertical line counter
//   displayArea  active-video flag, one cycle behind the counters
//   kill_valid   one-cycle pulse that destroys alien (kill_col, kill_row)
//   kill_col     column of the alien to destroy
//   kill_row     row of the alien to destroy
//   alien_pixel  current pixel is a lit pixel of a live alien
//   pixel_col    column of that alien, 0 when alien_pixel=0
//   pixel_row    row of that alien, 0 when alien_pixel=0
//   form_x       formation left edge
//   form_y       formation top edge
//   alive        alive mask, bit = row*COLS+col
//   landed       formation reached LAND_Y, sticky until reset
//   all_dead     alive mask is empty
module invader_formation #(
  parameter int COLS            = 8,
  parameter int ROWS            = 4,
  parameter int PITCH           = 32,
  parameter int START_X         = 64,
  parameter int START_Y         = 48,
  parameter int STEP_PX         = 4,
  parameter int DROP_PX         = 16,
  parameter int FRAMES_PER_STEP = 30,
  parameter int X_MAX           = 640,
  parameter int LAND_Y          = 400
) (
  input  logic                   VGA_clk,
  input  logic                   resetn,
  input  logic [9:0]             xCount,
  input  logic [9:0]             yCount,
  input  logic                   displayArea,
  input  logic                   kill_valid,
  input  logic [2:0]             kill_col,
  input  logic [1:0]             kill_row,
  output logic                   alien_pixel,
  output logic [2:0]             pixel_col,
  output logic [1:0]             pixel_row,
  output logic [9:0]             form_x,
  output logic [9:0]             form_y,
  output logic [COLS*ROWS-1:0]   alive,
  output logic                   landed,
  output logic                   all_dead
);

  localparam int FW    = COLS * PITCH - (PITCH - 16);
  localparam int FH    = ROWS * PITCH - (PITCH - 16);
  localparam int LOG2P = $clog2(PITCH);
  localparam int N     = COLS * ROWS;
  localparam int IW    = $clog2(N);
  localparam int CW    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  // Two 8x8 animation frames; bit index = {frame, row, col}.
  localparam logic [127:0] BITMAP = {
    8'h42, 8'h81, 8'h5A, 8'hFF, 8'hFF, 8'hDB, 8'h7E, 8'h3C,
    8'hA5, 8'h5A, 8'h24, 8'hFF, 8'hFF, 8'hDB, 8'h7E, 8'h3C
  };

  typedef enum logic {MARCH, HALT} state_t;

  state_t          r_state;
  logic            r_dir;        // 0 = right, 1 = left
  logic            r_anim;
  logic [CW-1:0]   r_frame_cnt;
  logic [9:0]      r_form_x;
  logic [9:0]      r_form_y;
  logic [N-1:0]    r_alive;
  logic            r_landed;
  logic [10:0]     r_rx;         // signed offset of pixel from formation origin
  logic [10:0]     r_ry;
  logic            r_alien_pixel;
  logic [2:0]      r_pixel_col;
  logic [1:0]      r_pixel_row;

  logic            w_frame_tick;
  logic            w_hit_right;
  logic            w_hit_left;
  logic            w_edge;
  logic [9:0]      w_next_x;
  logic [9:0]      w_next_y;
  logic            w_next_landed;
  logic            w_kill_ok;
  logic [IW-1:0]   w_kill_idx;
  logic            w_inside;
  logic [2:0]      w_col;
  logic [1:0]      w_row;
  logic [9:0]      w_sx;
  logic [9:0]      w_sy;
  logic            w_sprite;
  logic [IW-1:0]   w_pix_idx;
  logic [6:0]      w_bmp_idx;
  logic            w_hit;

  assign w_frame_tick = (xCount == 10'd0) && (yCount == 10'd480);

  // Edge test uses the full formation width, dead columns included.
  assign w_hit_right   = ({1'b0, r_form_x} + 11'(STEP_PX) + 11'(FW)) > 11'(X_MAX);
  assign w_hit_left    = r_form_x < 10'(STEP_PX);
  assign w_edge        = r_dir ? w_hit_left : w_hit_right;
  assign w_next_x      = w_edge ? r_form_x :
                         (r_dir ? r_form_x - 10'(STEP_PX) : r_form_x + 10'(STEP_PX));
  assign w_next_y      = w_edge ? r_form_y + 10'(DROP_PX) : r_form_y;
  assign w_next_landed = ({1'b0, w_next_y} + 11'(FH)) >= 11'(LAND_Y);

  assign w_kill_ok  = (32'(kill_col) < 32'(COLS)) && (32'(kill_row) < 32'(ROWS));
  assign w_kill_idx = IW'(kill_row) * IW'(COLS) + IW'(kill_col);

  // Render stage 2 decode from the registered offsets.
  assign w_inside  = !r_rx[10] && !r_ry[10] &&
                     (r_rx[9:0] < 10'(COLS * PITCH)) && (r_ry[9:0] < 10'(ROWS * PITCH));
  assign w_col     = 3'(r_rx[9:0] >> LOG2P);
  assign w_row     = 2'(r_ry[9:0] >> LOG2P);
  assign w_sx      = r_rx[9:0] & 10'(PITCH - 1);
  assign w_sy      = r_ry[9:0] & 10'(PITCH - 1);
  assign w_sprite  = (w_sx < 10'd16) && (w_sy < 10'd16);
  assign w_pix_idx = IW'(w_row) * IW'(COLS) + IW'(w_col);
  assign w_bmp_idx = {r_anim, w_sy[3:1], w_sx[3:1]};
  // displayArea already lags the counters by one cycle, matching stage 1.
  assign w_hit     = w_inside && w_sprite && r_alive[w_pix_idx] &&
                     BITMAP[w_bmp_idx] && displayArea;

  always_ff @(posedge VGA_clk) begin
    if (!resetn) begin
      r_state       <= MARCH;
      r_dir         <= 1'b0;
      r_anim        <= 1'b0;
      r_frame_cnt   <= '0;
      r_form_x      <= 10'(START_X);
      r_form_y      <= 10'(START_Y);
      r_alive       <= '1;
      r_landed      <= 1'b0;
      r_rx          <= 11'h400;
      r_ry          <= 11'h400;
      r_alien_pixel <= 1'b0;
      r_pixel_col   <= 3'd0;
      r_pixel_row   <= 2'd0;
    end else begin
      if (kill_valid && w_kill_ok) begin
        r_alive[w_kill_idx] <= 1'b0;
      end

      case (r_state)
        MARCH: begin
          if (all_dead) begin
            r_state <= HALT;
          end else if (w_frame_tick) begin
            if (r_frame_cnt == CW'(FRAMES_PER_STEP - 1)) begin
              r_frame_cnt <= '0;
              r_form_x    <= w_next_x;
              r_form_y    <= w_next_y;
              r_anim      <= ~r_anim;
              if (w_edge) begin
                r_dir <= ~r_dir;
              end
              if (w_next_landed) begin
                r_landed <= 1'b1;
                r_state  <= HALT;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + CW'(1);
            end
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: r_state <= HALT;
      endcase

      r_rx          <= {1'b0, xCount} - {1'b0, r_form_x};
      r_ry          <= {1'b0, yCount} - {1'b0, r_form_y};
      r_alien_pixel <= w_hit;
      r_pixel_col   <= w_hit ? w_col : 3'd0;
      r_pixel_row   <= w_hit ? w_row : 2'd0;
    end
  end

  assign alien_pixel = r_alien_pixel;
  assign pixel_col   = r_pixel_col;
  assign pixel_row   = r_pixel_row;
  assign form_x      = r_form_x;
  assign form_y      = r_form_y;
  assign alive       = r_alive;
  assign landed      = r_landed;
  assign all_dead    = ~|r_alive;

endmodule

// File: tb/tb_invader_formation.sv
// tb/tb_invader_formation.sv - directed bench for invader_formation with render scoreboard
module tb_invader_formation;

  logic        VGA_clk = 1'b0;
  logic        resetn;
  logic [9:0]  xCount;
  logic [9:0]  yCount;
  logic        displayArea;
  logic        kill_valid;
  logic [2:0]  kill_col;
  logic [1:0]  kill_row;

  logic        alien_pixel, landed, all_dead;
  logic [2:0]  pixel_col;
  logic [1:0]  pixel_row;
  logic [9:0]  form_x, form_y;
  logic [31:0] alive;

  logic        s_alien_pixel, s_landed, s_all_dead;
  logic [2:0]  s_pixel_col;
  logic [1:0]  s_pixel_row;
  logic [9:0]  s_form_x, s_form_y;
  logic [31:0] s_alive;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pix;
    logic [2:0] col;
    logic [1:0] row;
  } exp_t;
  exp_t sb[$];

  // Reference march model, FRAMES_PER_STEP = 1.
  int m_x, m_y, m_dir, m_halt, m_landed;

  always #5 VGA_clk = ~VGA_clk;

  invader_formation #(.FRAMES_PER_STEP(1)) u_dut (
    .VGA_clk(VGA_clk), .resetn(resetn), .xCount(xCount), .yCount(yCount),
    .displayArea(displayArea), .kill_valid(kill_valid), .kill_col(kill_col),
    .kill_row(kill_row), .alien_pixel(alien_pixel), .pixel_col(pixel_col),
    .pixel_row(pixel_row), .form_x(form_x), .form_y(form_y), .alive(alive),
    .landed(landed), .all_dead(all_dead)
  );

  invader_formation #(.FRAMES_PER_STEP(30)) u_dut30 (
    .VGA_clk(VGA_clk), .resetn(resetn), .xCount(xCount), .yCount(yCount),
    .displayArea(displayArea), .kill_valid(kill_valid), .kill_col(kill_col),
    .kill_row(kill_row), .alien_pixel(s_alien_pixel), .pixel_col(s_pixel_col),
    .pixel_row(s_pixel_row), .form_x(s_form_x), .form_y(s_form_y), .alive(s_alive),
    .landed(s_landed), .all_dead(s_all_dead)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge VGA_clk);
    #1;
  endtask

  task automatic idle();
    xCount = 10'd700;
    yCount = 10'd520;
    displayArea = 1'b0;
  endtask

  task automatic model_reset();
    m_x = 64; m_y = 48; m_dir = 0; m_halt = 0; m_landed = 0;
  endtask

  task automatic model_step();
    if (m_halt == 0) begin
      if (m_dir == 0) begin
        if (m_x + 4 + 240 > 640) begin m_y += 16; m_dir = 1; end
        else m_x += 4;
      end else begin
        if (m_x < 4) begin m_y += 16; m_dir = 0; end
        else m_x -= 4;
      end
      if (m_y + 112 >= 400) begin m_landed = 1; m_halt = 1; end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      xCount = 10'd0;
      yCount = 10'd480;
      cyc();
      idle();
      cyc();
      model_step();
    end
  endtask

  task automatic kill(input logic [2:0] c, input logic [1:0] r);
    kill_valid = 1'b1;
    kill_col = c;
    kill_row = r;
    cyc();
    kill_valid = 1'b0;
  endtask

  task automatic render(input logic [9:0] x, input logic [9:0] y, input logic disp,
                        input logic ep, input logic [2:0] ec, input logic [1:0] er);
    exp_t e;
    exp_t got;
    e.pix = ep; e.col = ec; e.row = er;
    sb.push_back(e);
    xCount = x;
    yCount = y;
    displayArea = disp;
    cyc();
    cyc();
    got = sb.pop_front();
    chk("render_pix", 32'(alien_pixel), 32'(got.pix));
    chk("render_col", 32'(pixel_col), 32'(got.col));
    chk("render_row", 32'(pixel_row), 32'(got.row));
    idle();
  endtask

  initial begin
    resetn = 1'b1;
    kill_valid = 1'b0;
    kill_col = 3'd0;
    kill_row = 2'd0;
    idle();
    cyc();

    do_reset();
    chk("reset_form_x", 32'(form_x), 32'd64);
    chk("reset_form_y", 32'(form_y), 32'd48);
    chk("reset_alive", alive, 32'hFFFF_FFFF);
    chk("reset_landed", 32'(landed), 32'd0);
    chk("reset_alien_pixel", 32'(alien_pixel), 32'd0);
    chk("reset_all_dead", 32'(all_dead), 32'd0);
    chk("reset_form_x_30", 32'(s_form_x), 32'd64);

    ticks(3);
    chk("march3_form_x", 32'(form_x), 32'd76);
    chk("march3_form_y", 32'(form_y), 32'd48);
    ticks(26);
    chk("fps30_29_ticks", 32'(s_form_x), 32'd64);
    ticks(1);
    chk("fps30_30_ticks", 32'(s_form_x), 32'd68);
    chk("march30_form_x", 32'(form_x), 32'(m_x));

    ticks(54);
    chk("edge_form_x", 32'(form_x), 32'd400);
    chk("edge_form_y", 32'(form_y), 32'd48);
    ticks(1);
    chk("drop_form_x", 32'(form_x), 32'd400);
    chk("drop_form_y", 32'(form_y), 32'd64);
    ticks(1);
    chk("left_form_x", 32'(form_x), 32'd396);
    chk("left_form_y", 32'(form_y), 32'd64);

    do_reset();
    render(10'd64, 10'd54, 1'b1, 1'b1, 3'd0, 2'd0);
    render(10'd84, 10'd54, 1'b1, 1'b0, 3'd0, 2'd0);
    render(10'd64, 10'd48, 1'b1, 1'b0, 3'd0, 2'd0);
    render(10'd70, 10'd48, 1'b1, 1'b1, 3'd0, 2'd0);
    render(10'd164, 10'd120, 1'b1, 1'b1, 3'd3, 2'd2);
    render(10'd164, 10'd120, 1'b0, 1'b0, 3'd0, 2'd0);
    render(10'd10, 10'd10, 1'b1, 1'b0, 3'd0, 2'd0);

    kill(3'd0, 2'd0);
    chk("kill_alive", alive, 32'hFFFF_FFFE);
    render(10'd64, 10'd54, 1'b1, 1'b0, 3'd0, 2'd0);
    kill(3'd0, 2'd0);
    chk("rekill_alive", alive, 32'hFFFF_FFFE);
    kill_valid = 1'b1;
    kill_col = 3'd7;
    kill_row = 2'd3;
    xCount = 10'd0;
    yCount = 10'd480;
    cyc();
    kill_valid = 1'b0;
    idle();
    model_step();
    chk("kill_tick_alive", alive, 32'h7FFF_FFFE);
    chk("kill_tick_form_x", 32'(form_x), 32'(m_x));
    chk("kill_tick_form_x_const", 32'(form_x), 32'd68);
    render(10'd100, 10'd54, 1'b1, 1'b1, 3'd1, 2'd0);

    do_reset();
    for (int i = 0; i < 2000 && m_landed == 0; i++) begin
      ticks(1);
    end
    chk("land_form_y", 32'(form_y), 32'd288);
    chk("land_form_x", 32'(form_x), 32'(m_x));
    chk("land_flag", 32'(landed), 32'd1);
    ticks(5);
    chk("halt_form_x", 32'(form_x), 32'(m_x));
    chk("halt_form_y", 32'(form_y), 32'd288);
    render(10'd100, 10'd294, 1'b1, 1'b0, 3'd0, 2'd0);

    do_reset();
    chk("land_cleared", 32'(landed), 32'd0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        kill(3'(c), 2'(r));
      end
    end
    chk("all_dead_flag", 32'(all_dead), 32'd1);
    chk("all_dead_alive", alive, 32'd0);
    cyc();
    ticks(2);
    chk("all_dead_halt_x", 32'(form_x), 32'd64);
    chk("all_dead_halt_y", 32'(form_y), 32'd48);
    render(10'd64, 10'd54, 1'b1, 1'b0, 3'd0, 2'd0);

    do_reset();
    chk("final_form_x", 32'(form_x), 32'd64);
    chk("final_form_y", 32'(form_y), 32'd48);
    chk("final_alive", alive, 32'hFFFF_FFFF);
    chk("final_all_dead", 32'(all_dead), 32'd0);
    chk("final_landed", 32'(landed), 32'd0);
    ticks(1);
    chk("final_march", 32'(form_x), 32'd68);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
